// File: rtl/dfi_cmd_sched.sv
// dfi_cmd_sched: arbitrates per-bank ACT/RD/WR/PRE and refresh requests onto the DFI command bus.
// Optional feature macro SCHED_ODT_EN: drives dfi_odt around write data windows (tied 0 otherwise).
module dfi_cmd_sched #(
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned RA_WIDTH   = 14,
    parameter int unsigned CA_WIDTH   = 10,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned TW         = 4,
    localparam int unsigned BA_WIDTH  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cke_en_i,
    input  logic [NUM_BANKS-1:0]          act_req_i,
    input  logic [NUM_BANKS-1:0]          rd_req_i,
    input  logic [NUM_BANKS-1:0]          wr_req_i,
    input  logic [NUM_BANKS-1:0]          pre_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0] ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0] ca_i,
    input  logic                          ref_req_i,
    output logic [NUM_BANKS-1:0]          act_gnt_o,
    output logic [NUM_BANKS-1:0]          rd_gnt_o,
    output logic [NUM_BANKS-1:0]          wr_gnt_o,
    output logic [NUM_BANKS-1:0]          pre_gnt_o,
    output logic                          ref_gnt_o,
    input  logic [TW-1:0]                 t_rrd_m1,
    input  logic [TW-1:0]                 t_ccd_m1,
    input  logic [TW-1:0]                 t_wtr_m1,
    input  logic [TW-1:0]                 t_rtw_m1,
    input  logic [3:0]                    dfi_wren_lat,
    input  logic [3:0]                    dfi_rden_lat,
    output logic                          dfi_cke,
    output logic                          dfi_cs_n,
    output logic                          dfi_ras_n,
    output logic                          dfi_cas_n,
    output logic                          dfi_we_n,
    output logic [BA_WIDTH-1:0]           dfi_ba,
    output logic [ADDR_WIDTH-1:0]         dfi_addr,
    output logic                          dfi_odt,
    output logic                          dfi_wrdata_en,
    output logic                          dfi_rddata_en
);
    // Stored taps; the bit entering this cycle completes the 16-deep line.
    localparam int unsigned LINE_W  = 15;
`ifdef SCHED_ODT_EN
    localparam int unsigned WLINE_W = 16;
`else
    localparam int unsigned WLINE_W = 15;
`endif
    localparam int unsigned WIDX_W  = $clog2(WLINE_W + 1);
    localparam int unsigned SPAN_W  = WIDX_W + 1;

    logic [TW-1:0]         rrd_cnt, ccd_cnt, wtr_cnt, rtw_cnt;
    logic [BA_WIDTH-1:0]   cas_ptr, act_ptr, pre_ptr;
    logic [LINE_W-1:0]     rd_line;
    logic [WLINE_W-1:0]    wr_line;
    logic [LINE_W:0]       rd_line_nx;
    logic [WLINE_W:0]      wr_line_nx;
    logic                  odt_nx;

    logic [RA_WIDTH-1:0]   ra_arr [NUM_BANKS];
    logic [CA_WIDTH-1:0]   ca_arr [NUM_BANKS];
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_unpack
        assign ra_arr[b] = ra_i[b*RA_WIDTH +: RA_WIDTH];
        assign ca_arr[b] = ca_i[b*CA_WIDTH +: CA_WIDTH];
    end

    function automatic logic [BA_WIDTH-1:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                    input logic [BA_WIDTH-1:0]  ptr);
        logic                found;
        logic [BA_WIDTH-1:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            idx = BA_WIDTH'((32'(ptr) + i) % NUM_BANKS);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [BA_WIDTH-1:0] next_bank(input logic [BA_WIDTH-1:0] b);
        return (b == BA_WIDTH'(NUM_BANKS - 1)) ? '0 : b + BA_WIDTH'(1);
    endfunction

    function automatic logic [TW-1:0] cnt_next(input logic load, input logic [TW-1:0] val,
                                               input logic [TW-1:0] cnt);
        if (load)          return val;
        else if (cnt != '0) return cnt - TW'(1);
        else               return cnt;
    endfunction

    logic                 act_ok, rd_ok, wr_ok, can_issue;
    logic [NUM_BANKS-1:0] cas_elig, act_elig;
    assign act_ok    = (rrd_cnt == '0);
    assign rd_ok     = (ccd_cnt == '0) && (wtr_cnt == '0);
    assign wr_ok     = (ccd_cnt == '0) && (rtw_cnt == '0);
    assign can_issue = rst_n && cke_en_i;
    assign cas_elig  = (rd_req_i & {NUM_BANKS{rd_ok}}) | (wr_req_i & {NUM_BANKS{wr_ok}});
    assign act_elig  = act_req_i & {NUM_BANKS{act_ok}};

    logic                  gnt_ref, gnt_rd, gnt_wr, gnt_act, gnt_pre;
    logic [BA_WIDTH-1:0]   sel_bank;
    logic                  ras_nx, cas_nx, we_nx;
    logic [BA_WIDTH-1:0]   ba_nx;
    logic [ADDR_WIDTH-1:0] addr_nx, ca_addr;

    // Class arbitration: an illegal higher class falls through to the next one.
    always_comb begin
        gnt_ref  = 1'b0;
        gnt_rd   = 1'b0;
        gnt_wr   = 1'b0;
        gnt_act  = 1'b0;
        gnt_pre  = 1'b0;
        sel_bank = '0;
        if (can_issue) begin
            if (ref_req_i && act_ok) begin
                gnt_ref = 1'b1;
            end else if (|cas_elig) begin
                sel_bank = rr_pick(cas_elig, cas_ptr);
                if (rd_req_i[sel_bank] && rd_ok) gnt_rd = 1'b1;
                else                             gnt_wr = 1'b1;
            end else if (|act_elig) begin
                sel_bank = rr_pick(act_elig, act_ptr);
                gnt_act  = 1'b1;
            end else if (|pre_req_i) begin
                sel_bank = rr_pick(pre_req_i, pre_ptr);
                gnt_pre  = 1'b1;
            end
        end
    end

    assign ref_gnt_o = gnt_ref;
    assign act_gnt_o = gnt_act ? (NUM_BANKS'(1) << sel_bank) : '0;
    assign rd_gnt_o  = gnt_rd  ? (NUM_BANKS'(1) << sel_bank) : '0;
    assign wr_gnt_o  = gnt_wr  ? (NUM_BANKS'(1) << sel_bank) : '0;
    assign pre_gnt_o = gnt_pre ? (NUM_BANKS'(1) << sel_bank) : '0;

    // Command encoding for the next DFI cycle; NOP holds ba/addr.
    always_comb begin
        ras_nx  = 1'b1;
        cas_nx  = 1'b1;
        we_nx   = 1'b1;
        ba_nx   = dfi_ba;
        addr_nx = dfi_addr;
        ca_addr = ADDR_WIDTH'(ca_arr[sel_bank]);
        ca_addr[10] = 1'b0;
        if (gnt_ref) begin
            {ras_nx, cas_nx, we_nx} = 3'b001;
            ba_nx = '0;
        end else if (gnt_rd || gnt_wr) begin
            {ras_nx, cas_nx, we_nx} = gnt_rd ? 3'b101 : 3'b100;
            ba_nx   = sel_bank;
            addr_nx = ca_addr;
        end else if (gnt_act) begin
            {ras_nx, cas_nx, we_nx} = 3'b011;
            ba_nx   = sel_bank;
            addr_nx = ADDR_WIDTH'(ra_arr[sel_bank]);
        end else if (gnt_pre) begin
            {ras_nx, cas_nx, we_nx} = 3'b010;
            ba_nx   = sel_bank;
            addr_nx = '0;
        end
    end

    assign rd_line_nx = {rd_line, gnt_rd};
    assign wr_line_nx = {wr_line, gnt_wr};

`ifdef SCHED_ODT_EN
    logic [WLINE_W:0] odt_mask;
    logic [SPAN_W-1:0] odt_span;
    // Window covers WR command cycle through wrdata_en cycle plus one.
    always_comb begin
        odt_span = SPAN_W'(dfi_wren_lat) + SPAN_W'(2);
        odt_mask = ((WLINE_W+1)'(1) << odt_span) - (WLINE_W+1)'(1);
        odt_nx   = (|(wr_line_nx & odt_mask)) && !rd_line_nx[dfi_rden_lat];
    end
`else
    assign odt_nx = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dfi_cke       <= 1'b0;
            dfi_cs_n      <= 1'b1;
            dfi_ras_n     <= 1'b1;
            dfi_cas_n     <= 1'b1;
            dfi_we_n      <= 1'b1;
            dfi_ba        <= '0;
            dfi_addr      <= '0;
            dfi_odt       <= 1'b0;
            dfi_wrdata_en <= 1'b0;
            dfi_rddata_en <= 1'b0;
            rrd_cnt       <= '0;
            ccd_cnt       <= '0;
            wtr_cnt       <= '0;
            rtw_cnt       <= '0;
            cas_ptr       <= '0;
            act_ptr       <= '0;
            pre_ptr       <= '0;
            rd_line       <= '0;
            wr_line       <= '0;
        end else begin
            dfi_cke       <= cke_en_i;
            dfi_cs_n      <= 1'b0;
            dfi_ras_n     <= ras_nx;
            dfi_cas_n     <= cas_nx;
            dfi_we_n      <= we_nx;
            dfi_ba        <= ba_nx;
            dfi_addr      <= addr_nx;
            dfi_odt       <= odt_nx;
            dfi_rddata_en <= rd_line_nx[dfi_rden_lat];
            dfi_wrdata_en <= wr_line_nx[WIDX_W'(dfi_wren_lat)];
            rd_line       <= rd_line_nx[LINE_W-1:0];
            wr_line       <= wr_line_nx[WLINE_W-1:0];
            rrd_cnt       <= cnt_next(gnt_act || gnt_ref, t_rrd_m1, rrd_cnt);
            ccd_cnt       <= cnt_next(gnt_rd || gnt_wr, t_ccd_m1, ccd_cnt);
            wtr_cnt       <= cnt_next(gnt_wr, t_wtr_m1, wtr_cnt);
            rtw_cnt       <= cnt_next(gnt_rd, t_rtw_m1, rtw_cnt);
            if (gnt_rd || gnt_wr) cas_ptr <= next_bank(sel_bank);
            if (gnt_act)          act_ptr <= next_bank(sel_bank);
            if (gnt_pre)          pre_ptr <= next_bank(sel_bank);
        end
    end
endmodule

// File: tb/tb_dfi_cmd_sched.sv
// Scoreboard bench for dfi_cmd_sched: grants checked in-cycle, DFI commands and data enables via queues.
module tb_dfi_cmd_sched;
    localparam logic [2:0] K_ACT = 3'b011;
    localparam logic [2:0] K_RD  = 3'b101;
    localparam logic [2:0] K_WR  = 3'b100;
    localparam logic [2:0] K_PRE = 3'b010;
    localparam logic [2:0] K_REF = 3'b001;

    typedef struct {
        int          cyc;
        logic [2:0]  kind;
        logic [1:0]  ba;
        logic [13:0] addr;
        logic [13:0] mask;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke_en_i;
    logic [3:0]  act_req_i, rd_req_i, wr_req_i, pre_req_i;
    logic [55:0] ra_i;
    logic [39:0] ca_i;
    logic        ref_req_i;
    logic [3:0]  act_gnt_o, rd_gnt_o, wr_gnt_o, pre_gnt_o;
    logic        ref_gnt_o;
    logic [3:0]  t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
    logic [3:0]  dfi_wren_lat, dfi_rden_lat;
    logic        dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [1:0]  dfi_ba;
    logic [13:0] dfi_addr;
    logic        dfi_odt, dfi_wrdata_en, dfi_rddata_en;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    cmd_t cmd_q[$];
    int   rden_q[$];
    int   wren_q[$];
    logic [13:0] ra_v [4];
    logic [9:0]  ca_v [4];
    int k, t, u, v, w, x;

    dfi_cmd_sched dut (
        .clk(clk), .rst_n(rst_n), .cke_en_i(cke_en_i),
        .act_req_i(act_req_i), .rd_req_i(rd_req_i), .wr_req_i(wr_req_i), .pre_req_i(pre_req_i),
        .ra_i(ra_i), .ca_i(ca_i), .ref_req_i(ref_req_i),
        .act_gnt_o(act_gnt_o), .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o), .pre_gnt_o(pre_gnt_o),
        .ref_gnt_o(ref_gnt_o),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1),
        .dfi_wren_lat(dfi_wren_lat), .dfi_rden_lat(dfi_rden_lat),
        .dfi_cke(dfi_cke), .dfi_cs_n(dfi_cs_n), .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n),
        .dfi_we_n(dfi_we_n), .dfi_ba(dfi_ba), .dfi_addr(dfi_addr), .dfi_odt(dfi_odt),
        .dfi_wrdata_en(dfi_wrdata_en), .dfi_rddata_en(dfi_rddata_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] gvec();
        return {ref_gnt_o, pre_gnt_o, wr_gnt_o, rd_gnt_o, act_gnt_o};
    endfunction

    // cls: 0 act, 1 rd, 2 wr, 3 pre, 4 ref
    function automatic logic [16:0] g(input int cls, input int b);
        return 17'(1) << (cls * 4 + b);
    endfunction

    task automatic exp_cmd(input int c, input logic [2:0] kind, input int b,
                           input logic [13:0] a, input logic [13:0] m);
        cmd_t e;
        e.cyc = c; e.kind = kind; e.ba = 2'(b); e.addr = a; e.mask = m;
        cmd_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Output monitor: every non-NOP command and data enable must match the queue head.
    always @(negedge clk) begin
        cmd_t e;
        int   c;
        if (rst_n) begin
            if (!dfi_cs_n && {dfi_ras_n, dfi_cas_n, dfi_we_n} != 3'b111) begin
                if (cmd_q.size() == 0) check("cmd_unexpected", 32'(1), 32'(0));
                else begin
                    e = cmd_q.pop_front();
                    check("cmd_cycle", 32'(cyc), 32'(e.cyc));
                    check("cmd_kind", 32'({dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'(e.kind));
                    check("cmd_ba", 32'(dfi_ba), 32'(e.ba));
                    check("cmd_addr", 32'(dfi_addr & e.mask), 32'(e.addr & e.mask));
                end
            end
            if (dfi_rddata_en) begin
                if (rden_q.size() == 0) check("rden_unexpected", 32'(1), 32'(0));
                else begin
                    c = rden_q.pop_front();
                    check("rden_cycle", 32'(cyc), 32'(c));
                end
            end
            if (dfi_wrdata_en) begin
                if (wren_q.size() == 0) check("wren_unexpected", 32'(1), 32'(0));
                else begin
                    c = wren_q.pop_front();
                    check("wren_cycle", 32'(cyc), 32'(c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ra_v = '{14'h0123, 14'h02AB, 14'h1C3D, 14'h3E0F};
        ca_v = '{10'h155, 10'h2AA, 10'h0F3, 10'h3C1};
        for (int b = 0; b < 4; b++) begin
            ra_i[b*14 +: 14] = ra_v[b];
            ca_i[b*10 +: 10] = ca_v[b];
        end
        rst_n = 1'b0; cke_en_i = 1'b0;
        act_req_i = 4'b1111; rd_req_i = '0; wr_req_i = '0; pre_req_i = '0; ref_req_i = 1'b1;
        t_rrd_m1 = '0; t_ccd_m1 = '0; t_wtr_m1 = '0; t_rtw_m1 = '0;
        dfi_wren_lat = 4'd2; dfi_rden_lat = 4'd5;

        // Reset state, grants suppressed despite requests
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gvec()), 32'(0));
        check("rst_ctl", 32'({dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt,
                              dfi_wrdata_en, dfi_rddata_en}), 32'(8'b0111_1000));
        check("rst_ba_addr", 32'({dfi_ba, dfi_addr}), 32'(0));
        act_req_i = '0; ref_req_i = 1'b0;
        step();
        rst_n = 1'b1; cke_en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("idle_nop", 32'({dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n}), 32'(5'b10111));
            check("idle_gnt", 32'(gvec()), 32'(0));
        end

        // tRRD spacing and ACT round robin
        t_rrd_m1 = 4'd2;
        step();
        k = cyc; act_req_i = 4'b0011;
        exp_cmd(k + 1, K_ACT, 0, ra_v[0], 14'h3FFF);
        exp_cmd(k + 4, K_ACT, 1, ra_v[1], 14'h3FFF);
        exp_cmd(k + 7, K_ACT, 0, ra_v[0], 14'h3FFF);
        for (int i = 0; i < 7; i++) begin
            logic [16:0] ea;
            ea = (i == 0 || i == 6) ? g(0, 0) : (i == 3) ? g(0, 1) : 17'(0);
            @(negedge clk);
            check("rrd_act_gnt", 32'(gvec()), 32'(ea));
            step();
        end
        act_req_i = '0;

        // tWTR gating WR->RD, data enable latencies
        t_wtr_m1 = 4'd3; t_ccd_m1 = 4'd1; t_rtw_m1 = 4'd0;
        idle(3);
        t = cyc; wr_req_i = 4'b0100;
        @(negedge clk);
        check("wtr_wr_gnt", 32'(gvec()), 32'(g(2, 2)));
        exp_cmd(t + 1, K_WR, 2, 14'(ca_v[2]), 14'h3FFF);
        wren_q.push_back(t + 3);
        step();
        wr_req_i = '0; rd_req_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wtr_rd_hold", 32'(gvec()), 32'(0));
            step();
        end
        @(negedge clk);
        check("wtr_rd_gnt", 32'(gvec()), 32'(g(1, 2)));
        exp_cmd(t + 5, K_RD, 2, 14'(ca_v[2]), 14'h3FFF);
        rden_q.push_back(t + 10);
        step();
        rd_req_i = '0;

        // Back-to-back reads with tCCD=1 cycle, overlapping in the shift line
        t_ccd_m1 = 4'd0;
        idle(6);
        u = cyc; rd_req_i = 4'b0011;
        @(negedge clk);
        check("b2b_rd0_gnt", 32'(gvec()), 32'(g(1, 0)));
        exp_cmd(u + 1, K_RD, 0, 14'(ca_v[0]), 14'h3FFF);
        rden_q.push_back(u + 6);
        step();
        @(negedge clk);
        check("b2b_rd1_gnt", 32'(gvec()), 32'(g(1, 1)));
        exp_cmd(u + 2, K_RD, 1, 14'(ca_v[1]), 14'h3FFF);
        rden_q.push_back(u + 7);
        step();
        rd_req_i = '0;

        // Class priority REF > CAS > ACT, ACT gated by rrd after REF
        t_rrd_m1 = 4'd2;
        idle(2);
        v = cyc; ref_req_i = 1'b1; rd_req_i = 4'b0010; act_req_i = 4'b1000;
        @(negedge clk);
        check("prio_ref_gnt", 32'(gvec()), 32'(g(4, 0)));
        exp_cmd(v + 1, K_REF, 0, 14'h0, 14'h0);
        step();
        ref_req_i = 1'b0;
        @(negedge clk);
        check("prio_rd_gnt", 32'(gvec()), 32'(g(1, 1)));
        exp_cmd(v + 2, K_RD, 1, 14'(ca_v[1]), 14'h3FFF);
        rden_q.push_back(v + 7);
        step();
        rd_req_i = '0;
        @(negedge clk);
        check("prio_act_wait", 32'(gvec()), 32'(0));
        step();
        @(negedge clk);
        check("prio_act_gnt", 32'(gvec()), 32'(g(0, 3)));
        exp_cmd(v + 4, K_ACT, 3, ra_v[3], 14'h3FFF);
        step();
        act_req_i = '0;

        // No grants while cke_en_i is low
        idle(3);
        cke_en_i = 1'b0; act_req_i = 4'b0001;
        @(negedge clk);
        check("cke_off_gnt", 32'(gvec()), 32'(0));
        step();
        @(negedge clk);
        check("cke_off_gnt2", 32'(gvec()), 32'(0));
        check("cke_off_pin", 32'(dfi_cke), 32'(0));
        step();
        act_req_i = '0; cke_en_i = 1'b1;

        // tRTW blocks WR, PRE slips through
        t_rtw_m1 = 4'd3;
        idle(2);
        w = cyc; rd_req_i = 4'b0001;
        @(negedge clk);
        check("rtw_rd_gnt", 32'(gvec()), 32'(g(1, 0)));
        exp_cmd(w + 1, K_RD, 0, 14'(ca_v[0]), 14'h3FFF);
        rden_q.push_back(w + 6);
        step();
        rd_req_i = '0; wr_req_i = 4'b0010; pre_req_i = 4'b0001;
        @(negedge clk);
        check("rtw_pre_gnt", 32'(gvec()), 32'(g(3, 0)));
        exp_cmd(w + 2, K_PRE, 0, 14'h0, 14'h0400);
        step();
        pre_req_i = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rtw_wr_wait", 32'(gvec()), 32'(0));
            step();
        end
        @(negedge clk);
        check("rtw_wr_gnt", 32'(gvec()), 32'(g(2, 1)));
        exp_cmd(w + 5, K_WR, 1, 14'(ca_v[1]), 14'h3FFF);
        wren_q.push_back(w + 7);
        step();
        wr_req_i = '0;

        // Reset mid-operation: pending read enable dropped, counters and pointers cleared
        t_rrd_m1 = 4'd3;
        idle(3);
        x = cyc; rd_req_i = 4'b0100;
        @(negedge clk);
        check("mid_rd_gnt", 32'(gvec()), 32'(g(1, 2)));
        exp_cmd(x + 1, K_RD, 2, 14'(ca_v[2]), 14'h3FFF);
        step();
        rd_req_i = '0; act_req_i = 4'b0001;
        @(negedge clk);
        check("mid_act_gnt", 32'(gvec()), 32'(g(0, 0)));
        step();
        act_req_i = '0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctl", 32'({dfi_cke, dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_odt,
                                  dfi_wrdata_en, dfi_rddata_en}), 32'(8'b0111_1000));
        check("mid_rst_ba_addr", 32'({dfi_ba, dfi_addr}), 32'(0));
        #1;
        rst_n = 1'b1;
        step();
        act_req_i = 4'b0011;
        @(negedge clk);
        check("mid_act_after_rst", 32'(gvec()), 32'(g(0, 0)));
        exp_cmd(x + 4, K_ACT, 0, ra_v[0], 14'h3FFF);
        step();
        act_req_i = '0;
        idle(10);

        check("cmd_q_drained", 32'(cmd_q.size()), 32'(0));
        check("rden_q_drained", 32'(rden_q.size()), 32'(0));
        check("wren_q_drained", 32'(wren_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dfi_cmd_sched.md
Name: dfi_cmd_sched

Overview:
Command scheduler between the per-bank controllers and the DFI control/data-enable bus. Each cycle it arbitrates ACT/RD/WR/PRE requests from NUM_BANKS bank controllers plus one refresh requester, and grants at most one request. It enforces the inter-bank timings tRRD, tCCD, tWTR and tRTW. It drives the registered DFI command, and pulses dfi_wrdata_en and dfi_rddata_en at the programmed DFI latencies.

Parameters:
NUM_BANKS, 4, number of bank requesters; BA_WIDTH = log2(NUM_BANKS)
RA_WIDTH, 14, row address width
CA_WIDTH, 10, column address width
ADDR_WIDTH, 14, DFI address width; must be >= RA_WIDTH and >= 11
TW, 4, width of the timing register inputs

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
cke_en_i  in  1  from init sequencer; registered onto dfi_cke
act_req_i / rd_req_i / wr_req_i / pre_req_i  in  NUM_BANKS each  per-bank requests
ra_i  in  NUM_BANKS*RA_WIDTH  per-bank row address, bank b at [b*RA_WIDTH +: RA_WIDTH]
ca_i  in  NUM_BANKS*CA_WIDTH  per-bank column address
ref_req_i  in  1  all-bank refresh request
act_gnt_o / rd_gnt_o / wr_gnt_o / pre_gnt_o  out  NUM_BANKS each  one-hot grants
ref_gnt_o  out  1  refresh grant
t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1  in  TW each  timing minus one, static
dfi_wren_lat, dfi_rden_lat  in  4 each  DFI latencies in cycles, static
dfi_cke  out  1
dfi_cs_n  out  1
dfi_ras_n, dfi_cas_n, dfi_we_n  out  1 each
dfi_ba  out  BA_WIDTH
dfi_addr  out  ADDR_WIDTH
dfi_odt  out  1
dfi_wrdata_en, dfi_rddata_en  out  1 each

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - dfi_cke=0, dfi_cs_n=1, ras/cas/we_n=1, ba=0, addr=0, odt=0.
  - Data enables 0; all counters 0; round-robin pointers 0.
  - Grant outputs are combinational and are 0 while rst_n=0.
- Grants and issue:
  - Grants are combinational in cycle T from requests and counter state. At most one grant bit is set across all grant outputs.
  - The DFI command is registered and appears in cycle T+1.
  - In a cycle with no grant, drive NOP: cs_n=0, ras/cas/we_n=1, ba/addr hold.
- Class priority: REF > RD/WR (CAS) > ACT > PRE.
  - Within one bank, rd > wr if both are asserted.
  - Within a class, round-robin over banks. The class pointer moves to granted_bank+1 mod NUM_BANKS on a grant in that class.
  - RD and WR share one CAS pointer.
- Legality (each counter loads on grant, decrements to 0, saturates at 0; a command is legal only when its counter is 0):
  - rrd_cnt: loaded with t_rrd_m1 on ACT or REF; gates ACT and REF.
  - ccd_cnt: loaded with t_ccd_m1 on RD or WR; gates RD and WR.
  - wtr_cnt: loaded with t_wtr_m1 on WR; gates RD.
  - rtw_cnt: loaded with t_rtw_m1 on RD; gates WR.
  - PRE is always legal.
  - An illegal higher class does not block a legal lower class (e.g. a pending RD blocked by tWTR lets an ACT through).
- Command encoding (ras/cas/we_n):
  - ACT 0/1/1: ba=bank, addr=ra zero-extended.
  - RD 1/0/1 and WR 1/0/0: addr=ca zero-extended, addr[10]=0.
  - PRE 0/1/0: addr[10]=0.
  - REF 0/0/1: ba=0.
- Data enables:
  - A 16-deep shift line per direction is tapped at the latency.
  - RD granted at T: dfi_rddata_en=1 for exactly one cycle at T+1+dfi_rden_lat.
  - WR granted at T: dfi_wrdata_en=1 for exactly one cycle at T+1+dfi_wren_lat.
  - Back-to-back CAS commands overlap in the shift line without loss.
- dfi_cke = registered cke_en_i.
  - While cke_en_i=0, no grants are given; counters still count down.
- Reset mid-operation clears counters, shift lines and pointers immediately. Pending data enables are dropped.
- A timing value of 0 (m1=0) permits the same command class on the next cycle.

Optional Feature:
SCHED_ODT_EN
- Defined: dfi_odt=1 from the cycle the WR command is driven through the cycle its dfi_wrdata_en asserts, plus one more cycle.
  - Overlapping windows merge.
  - odt is 0 during any RD data window.
- Undefined: dfi_odt is tied 0.

Test Plan:
- Reset release, cke_en_i=1, no requests -> dfi_cke=1 the next cycle; NOP (cs_n=0, ras/cas/we_n=1) every cycle; no grants.
- t_rrd_m1=2; act_req_i=4'b0011 held -> ACT bank0 at T, ACT bank1 at T+3; dfi_ba=0 then 1 one cycle later; round-robin returns to bank0 next.
- t_wtr_m1=3, t_ccd_m1=1; WR bank2 granted at T, RD bank2 requested at T+1 -> rd_gnt at T+4; dfi_wren_lat=2 gives dfi_wrdata_en at T+3; dfi_rden_lat=5 gives dfi_rddata_en at T+10.
- ref_req_i, rd_req_i[1], act_req_i[3] all asserted, counters 0 -> ref_gnt_o at T; rd_gnt_o[1] at T+1 (ccd free); act_gnt_o[3] granted only once rrd_cnt reaches 0.
- rtw_cnt busy with wr_req only, plus pre_req_i[0] -> PRE issued while WR waits; dfi_addr[10]=0.
- rst_n pulsed low with a read latency pending -> dfi_rddata_en never asserts; outputs at reset values asynchronously.
